// File: rtl/debounce_bank.sv
// debounce_bank: N-channel switch/button conditioner.
// Each raw input is optionally inverted, passed through a 2-flop synchroniser
// and debounced by a per-channel stability counter. Each channel produces a
// clean level plus one-cycle rise/fall pulses.
// Optional feature: define DEBOUNCE_BANK_REPEAT_EN to build per-channel hold
// counters that emit auto-repeat pulses while a channel is held active.
// Without the macro rep_sig is tied to zero and HOLD_CMAX/REP_CMAX are unused.
module debounce_bank #(
    parameter int unsigned  N         = 4,
    parameter int unsigned  CLK_KHZ   = 1000,             // clock cycles per millisecond
    parameter int unsigned  CMAX      = 5 * CLK_KHZ,
    parameter logic [N-1:0] INV       = {N{1'b0}},
    parameter int unsigned  HOLD_CMAX = 500 * CLK_KHZ,
    parameter int unsigned  REP_CMAX  = 100 * CLK_KHZ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_sig,
    output logic [N-1:0] sig,
    output logic [N-1:0] pe_sig,
    output logic [N-1:0] ne_sig,
    output logic [N-1:0] rep_sig,
    output logic         any_pe
);

    localparam int unsigned   CW       = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CMAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Reject illegal configurations at elaboration time.
    if ((N < 1) || (CMAX < 1) || (HOLD_CMAX < 1) || (REP_CMAX < 1)) begin : g_bad_param
        $error("debounce_bank: N, CMAX, HOLD_CMAX and REP_CMAX must all be >= 1");
    end

    logic [N-1:0]         s1_d, s1_q;
    logic [N-1:0]         s2_d, s2_q;
    logic [N-1:0][CW-1:0] cnt_d, cnt_q;
    logic [N-1:0]         sig_d, sig_q;
    logic [N-1:0]         pe_d, pe_q;
    logic [N-1:0]         ne_d, ne_q;
    logic                 any_pe_d, any_pe_q;

    // Synchroniser inputs: polarity correction happens before the first flop
    // so reset value 0 of s1/s2 is always the inactive level.
    always_comb begin
        s1_d = a_sig ^ INV;
        s2_d = s1_q;
    end

    // Debounce: a change is accepted only after CMAX consecutive mismatching
    // samples; any agreeing sample restarts the count.
    always_comb begin
        sig_d = sig_q;
        pe_d  = {N{1'b0}};
        ne_d  = {N{1'b0}};
        cnt_d = {N{{CW{1'b0}}}};
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] != sig_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sig_d[i] = ~sig_q[i];
                    pe_d[i]  = ~sig_q[i];
                    ne_d[i]  = sig_q[i];
                    cnt_d[i] = {CW{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = {CW{1'b0}};
            end
        end
        any_pe_d = |pe_d;
    end

    // Synchroniser, counters, level and edge-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= {N{1'b0}};
            s2_q     <= {N{1'b0}};
            cnt_q    <= {N{{CW{1'b0}}}};
            sig_q    <= {N{1'b0}};
            pe_q     <= {N{1'b0}};
            ne_q     <= {N{1'b0}};
            any_pe_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
            pe_q     <= pe_d;
            ne_q     <= ne_d;
            any_pe_q <= any_pe_d;
        end
    end

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int unsigned   HMAX      = (HOLD_CMAX > REP_CMAX) ? HOLD_CMAX : REP_CMAX;
    localparam int unsigned   HW        = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CMAX - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CMAX - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [N-1:0][HW-1:0] hold_d, hold_q;
    logic [N-1:0]         armed_d, armed_q;   // first repeat already issued
    logic [N-1:0]         rep_d, rep_q;
    logic [HW-1:0]        tgt_s;

    // Hold counter: runs while the level is high, fires after HOLD_CMAX cycles
    // and then every REP_CMAX cycles; a simultaneous fall wins over a repeat.
    always_comb begin
        hold_d  = {N{{HW{1'b0}}}};
        armed_d = {N{1'b0}};
        rep_d   = {N{1'b0}};
        tgt_s   = HOLD_LAST;
        for (int i = 0; i < N; i++) begin
            if (armed_q[i]) begin
                tgt_s = REP_LAST;
            end else begin
                tgt_s = HOLD_LAST;
            end
            if (sig_q[i] && !ne_d[i]) begin
                if (hold_q[i] == tgt_s) begin
                    rep_d[i]   = 1'b1;
                    hold_d[i]  = {HW{1'b0}};
                    armed_d[i] = 1'b1;
                end else begin
                    hold_d[i]  = hold_q[i] + HOLD_ONE;
                    armed_d[i] = armed_q[i];
                end
            end else begin
                hold_d[i]  = {HW{1'b0}};
                armed_d[i] = 1'b0;
            end
        end
    end

    // Hold counter and repeat pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= {N{{HW{1'b0}}}};
            armed_q <= {N{1'b0}};
            rep_q   <= {N{1'b0}};
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
        end
    end

    assign rep_sig = rep_q;
`else
    assign rep_sig = {N{1'b0}};
`endif

    assign sig    = sig_q;
    assign pe_sig = pe_q;
    assign ne_sig = ne_q;
    assign any_pe = any_pe_q;

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel switch/button conditioner. It synchronises N asynchronous raw inputs and debounces each one independently with a per-channel stability counter. Each channel produces a clean level plus registered one-cycle rise and fall pulses; an optional auto-repeat pulse supports held keys. It sits between board-level push-buttons/DIP switches and the control FSMs, replacing per-signal debouncer instances.

## Interface
- N, default 4: channel count, N >= 1.
- CMAX, default `c_ms(5)`: consecutive stable cycles required to accept a change, CMAX >= 1.
- INV, default {N{1'b0}}: per-channel polarity mask; bit set means the raw input is active-low and is inverted before debouncing.
- HOLD_CMAX, default `c_ms(500)`: cycles held active before the first repeat pulse (repeat build only).
- REP_CMAX, default `c_ms(100)`: cycles between subsequent repeat pulses (repeat build only).
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a_sig  input  N  raw asynchronous inputs.
- sig  output  N  debounced active-high levels, registered.
- pe_sig  output  N  one-cycle pulse when sig[i] rises, registered.
- ne_sig  output  N  one-cycle pulse when sig[i] falls, registered.
- rep_sig  output  N  one-cycle auto-repeat pulse while sig[i] is held high.
- any_pe  output  1  OR of pe_sig, registered in the same cycle as pe_sig.

## Operation
- Per channel i: a 2-flop synchroniser s1 then s2 on (a_sig[i] ^ INV[i]); then a counter cnt of width max(1, $clog2(CMAX)).
- mismatch = (s2 != sig[i]). On each edge:
  - If mismatch && cnt == CMAX-1: sig toggles, cnt <= 0, pe or ne <= 1 according to the new level.
  - Else if mismatch: cnt <= cnt+1.
  - Else: cnt <= 0.
  - pe/ne are 0 whenever no toggle occurs.
- Any single cycle of agreement (glitch back) clears cnt; acceptance needs CMAX consecutive mismatched cycles.
- Channels are fully independent. Simultaneous toggles on several channels all pulse in the same cycle.
- pe and ne are never high together on one channel.

## Timing
- Reset values: sig = 0, pe_sig = 0, ne_sig = 0, rep_sig = 0, any_pe = 0, cnt = 0, hold counters = 0. s1 and s2 reset to 0, i.e. the inactive level after inversion, so no spurious edge occurs after reset release even with active-low buttons released.
- Latency: a change first sampled into s1 at edge 0 and held stable is reflected in sig, pe/ne at edge CMAX+1, so visible in cycle CMAX+1. With CMAX=1 this is edge 2, which is synchroniser delay only.
- Pulses are high for exactly one cycle, aligned with the first cycle of the new sig level.
- Reset mid-count discards progress. After release, counting restarts from 0 against sig = 0.

## Configuration
- DEBOUNCE_BANK_REPEAT_EN defined:
  - Each channel has a hold counter of width $clog2(max(HOLD_CMAX, REP_CMAX)+1). It is cleared while sig[i] = 0 and counts while sig[i] = 1.
  - First rep_sig[i] pulse at HOLD_CMAX cycles after the pe_sig[i] cycle. The counter then reloads, and further pulses follow every REP_CMAX cycles until sig[i] falls.
  - A fall on the same cycle a repeat would fire suppresses that repeat.
- Not defined: rep_sig is constant 0, no hold counters are built, and HOLD_CMAX and REP_CMAX are ignored.

## Test plan
All scenarios use N=4, CMAX=8, INV=4'b1000, HOLD_CMAX=20, REP_CMAX=5.
- Glitch reject: a_sig[0] high for 7 cycles then low -> sig[0] stays 0, no pe_sig.
- Clean press: a_sig[0] 0->1, held 20 cycles -> sig[0] = 1 at edge 9 after first sample. pe_sig[0] and any_pe are high exactly that cycle.
- Release: a_sig[0] 1->0 held -> ne_sig[0] one cycle, 9 edges later; sig[0] = 0.
- Polarity/simultaneous: after reset with a_sig = 4'b1000, all outputs stay 0. Then a_sig -> 4'b0011 in one cycle -> pe_sig = 4'b1011 in a single cycle, sig = 4'b1011.
- Reset mid-count: a_sig[1] high; assert rst_n low at count 5 for 2 cycles; release -> sig[1] rises 9 edges after release, not earlier.
- Repeat (macro on): hold a_sig[2] high 40 cycles after pe -> rep_sig[2] pulses at +20, +25, +30, +35, +40 cycles. Macro off -> rep_sig = 0 throughout.
